switch_mcu_alu_exec_seq: RTL
============================

// Module: switch_mcu_alu_exec_seq
// PURPOSE
//  Parametrised multi-cycle execute sequencer; successor to the fixed 32-bit ALU top.
//  Accepts one encoded integer op per valid/ready handshake, reads operands from the regfile,
//  computes the result and writes it back.
//  Fixed latency, with a retire counter.
//  Sits between decode and switch_mcu_regfile; owns all regfile read/write port signals.
// PARAMETERS
//  XLEN    32  datapath width; power of 2, >=8; SHAMT_W = $clog2(XLEN) (localparam)
//  RA_W     5  register address width; address 0 is hard-wired zero
//  OP_W     4  op code width
//  CNT_W   16  retire counter width
// PORTS
//  in_clk        in   1       clock
//  in_rst        in   1       asynchronous, active-low reset
//  in_valid      in   1       op request valid
//  out_ready     out  1       sequencer can accept (high only in IDLE)
//  in_op         in   OP_W    0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 LUI,11 AUIPC
//  in_use_imm    in   1       operand B = in_imm instead of rs2 data
//  in_imm        in   XLEN    immediate, already sign-extended/shifted by decode
//  in_pc         in   XLEN    PC of op (AUIPC)
//  in_rs1/in_rs2 in   RA_W    source registers
//  in_rd         in   RA_W    destination register
//  out_raddr_1/2 out  RA_W    regfile read addresses
//  out_ren_1/2   out  1       regfile read enables
//  in_rdata_1/2  in   XLEN    regfile read data, valid the cycle after ren
//  out_waddr     out  RA_W    regfile write address
//  out_wen       out  1       regfile write enable
//  out_wdata     out  XLEN    regfile write data
//  out_done      out  1       1-cycle pulse: op retired
//  out_err       out  1       1-cycle pulse with out_done: illegal op (no write)
//  out_retire_cnt out CNT_W   ops retired without error
// BEHAVIOUR
//  Async reset: state=IDLE; out_ready=1; all other outputs and internal latches 0.
//  FSM: IDLE -(in_valid)-> RD -> EX -> WB -> IDLE; RD/EX/WB unconditional, one cycle each.
//  Accept when in_valid & out_ready in IDLE: latch op, use_imm, imm, pc, rs1, rs2, rd.
//  RD: out_ren_1=1 with out_raddr_1=rs1; out_ren_2=1 with out_raddr_2=rs2 unless use_imm.
//   LUI/AUIPC/illegal: both ren=0. rs==0 -> ren=0; operand treated as 0.
//  EX: operands sampled from in_rdata_*; result computed and registered.
//  WB: out_wen=1, out_waddr=rd, out_wdata=result; out_done=1.
//   rd==0 or illegal op -> out_wen=0; out_done still pulses.
//   Illegal op (in_op>=12): out_err=1, result 0.
//  Latency: accept in cycle T -> out_wen/out_done in cycle T+3. Next accept no earlier than T+4.
//   Throughput 1 op / 4 cycles.
//  All regfile outputs are registered and only asserted in their state; idle values are 0.
//  Arithmetic:
//   ADD/SUB/AUIPC wrap modulo 2^XLEN.
//   SLT signed compare, SLTU unsigned compare; result 0 or 1, zero-extended.
//   Shifts use B[SHAMT_W-1:0]; SRA is arithmetic.
//   LUI result = imm; AUIPC result = pc + imm.
//  out_retire_cnt increments in WB when out_err=0 (including rd==0); wraps to 0 at 2^CNT_W.
//  in_valid while not ready is ignored; no queueing; decode must hold the op until accepted.
//  Reset mid-operation aborts: no write is issued and the counter clears.
// CONFIGURATION
//  SWITCH_MCU_ALU_BYPASS_EN defined:
//   Last written (rd, result) is held after each WB with wen=1.
//   In RD, a source equal to that held rd (non-zero) is not read (ren=0); the held result is used in EX.
//   Latency and all other behaviour unchanged. Reset clears the held entry.
//  Undefined: no held entry; every non-zero source is read from the regfile.
// TESTING
//  1 Reset: in_rst low mid-EX -> next cycle IDLE, out_ready=1, wen/ren/done=0, cnt=0, no write.
//  2 ADD r3=r1+r2 with rdata 0x7FFFFFFF,0x00000001 (XLEN=32): ren at T+1; wen at T+3,
//    waddr=3, wdata=0x80000000; cnt=1.
//  3 SRA imm shamt=4 on 0x80000000 -> 0xF8000000; SLTU 0xFFFFFFFF<1 -> 0; SLT -1<1 -> 1.
//  4 LUI imm=0x12345000, rd=0 -> no ren, wen=0, done=1, err=0, cnt+1.
//    AUIPC pc=0xFFFFF000, imm=0x2000 -> 0x00001000.
//  5 in_op=13 -> done=1, err=1, wen=0, cnt unchanged.
//    in_valid held 4 cycles back-to-back -> exactly one accept per 4 cycles.
//  6 BYPASS_EN: ADD r5 then XOR r6=r5^r5 -> second op ren_1=ren_2=0, wdata=0.
//    Without macro -> ren_1=ren_2=1, same result.

Source files
------------

// File: rtl/switch_mcu_alu_exec_seq.sv
// switch_mcu_alu_exec_seq: fixed-latency execute sequencer (IDLE->RD->EX->WB) between decode and the regfile
// Ports: in_clk/in_rst (async, active-low); in_valid/out_ready handshake with in_op, in_use_imm, in_imm, in_pc,
//        in_rs1/in_rs2/in_rd; regfile read (out_raddr_*, out_ren_*, in_rdata_*) and write (out_waddr, out_wen,
//        out_wdata); out_done/out_err retire pulses; out_retire_cnt counts error-free retirements.
// SWITCH_MCU_ALU_BYPASS_EN: hold the last written (rd, result) and forward it instead of re-reading that register.
module switch_mcu_alu_exec_seq #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_use_imm,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic [RA_W-1:0]  in_rd,
    output logic [RA_W-1:0]  out_raddr_1,
    output logic [RA_W-1:0]  out_raddr_2,
    output logic             out_ren_1,
    output logic             out_ren_2,
    input  logic [XLEN-1:0]  in_rdata_1,
    input  logic [XLEN-1:0]  in_rdata_2,
    output logic [RA_W-1:0]  out_waddr,
    output logic             out_wen,
    output logic [XLEN-1:0]  out_wdata,
    output logic             out_done,
    output logic             out_err,
    output logic [CNT_W-1:0] out_retire_cnt
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0), OP_SUB = OP_W'(1), OP_SLL = OP_W'(2), OP_SLT = OP_W'(3),
                                OP_SLTU = OP_W'(4), OP_XOR = OP_W'(5), OP_SRL = OP_W'(6), OP_SRA = OP_W'(7),
                                OP_OR = OP_W'(8), OP_AND = OP_W'(9), OP_LUI = OP_W'(10), OP_AUIPC = OP_W'(11);
    typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;
    state_t state, state_nxt;
    logic [OP_W-1:0] op_q;
    logic use_imm_q;
    logic [XLEN-1:0] imm_q, pc_q, held_val, a, b, res;
    logic [RA_W-1:0] rd_q;
    logic rd_1_q, rd_2_q, byp_1_q, byp_2_q;
    logic accept, uses_rs, hit_1, hit_2, legal, ren_1_nxt, ren_2_nxt;
    logic [SHAMT_W-1:0] shamt;

    assign accept    = (state == IDLE) && in_valid;
    assign uses_rs   = in_op <= OP_AND;
    assign legal     = op_q <= OP_AUIPC;
    assign ren_1_nxt = uses_rs && in_rs1 != '0 && !hit_1;
    assign ren_2_nxt = uses_rs && !in_use_imm && in_rs2 != '0 && !hit_2;

`ifdef SWITCH_MCU_ALU_BYPASS_EN
    logic [RA_W-1:0] held_rd;
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            held_rd  <= '0;
            held_val <= '0;
        end else if (state == WB && out_wen) begin
            held_rd  <= out_waddr;
            held_val <= out_wdata;
        end
    end
    // held_rd is never 0 when valid, so a hit implies a non-zero source
    assign hit_1 = held_rd != '0 && in_rs1 == held_rd;
    assign hit_2 = held_rd != '0 && in_rs2 == held_rd;
`else
    assign held_val = '0;
    assign hit_1    = 1'b0;
    assign hit_2    = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? RD : IDLE;
            RD:      state_nxt = EX;
            EX:      state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    // register 0 and unread sources contribute 0; forwarded sources take the held result
    always_comb begin
        a     = rd_1_q ? in_rdata_1 : (byp_1_q ? held_val : '0);
        b     = use_imm_q ? imm_q : (rd_2_q ? in_rdata_2 : (byp_2_q ? held_val : '0));
        shamt = b[SHAMT_W-1:0];
        res   = '0;
        case (op_q)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_SLL:   res = a << shamt;
            OP_SLT:   res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:   res = a ^ b;
            OP_SRL:   res = a >> shamt;
            OP_SRA:   res = $signed(a) >>> shamt;
            OP_OR:    res = a | b;
            OP_AND:   res = a & b;
            OP_LUI:   res = imm_q;
            OP_AUIPC: res = pc_q + imm_q;
            default:  res = '0;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_ready      <= 1'b1;
            out_ren_1      <= 1'b0;
            out_ren_2      <= 1'b0;
            out_raddr_1    <= '0;
            out_raddr_2    <= '0;
            out_wen        <= 1'b0;
            out_waddr      <= '0;
            out_wdata      <= '0;
            out_done       <= 1'b0;
            out_err        <= 1'b0;
            out_retire_cnt <= '0;
            op_q           <= '0;
            use_imm_q      <= 1'b0;
            imm_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_1_q         <= 1'b0;
            rd_2_q         <= 1'b0;
            byp_1_q        <= 1'b0;
            byp_2_q        <= 1'b0;
        end else begin
            out_ready   <= state_nxt == IDLE;
            out_ren_1   <= 1'b0;
            out_ren_2   <= 1'b0;
            out_raddr_1 <= '0;
            out_raddr_2 <= '0;
            out_wen     <= 1'b0;
            out_waddr   <= '0;
            out_wdata   <= '0;
            out_done    <= 1'b0;
            out_err     <= 1'b0;
            if (accept) begin
                op_q        <= in_op;
                use_imm_q   <= in_use_imm;
                imm_q       <= in_imm;
                pc_q        <= in_pc;
                rd_q        <= in_rd;
                rd_1_q      <= ren_1_nxt;
                rd_2_q      <= ren_2_nxt;
                byp_1_q     <= uses_rs && hit_1;
                byp_2_q     <= uses_rs && !in_use_imm && hit_2;
                out_ren_1   <= ren_1_nxt;
                out_ren_2   <= ren_2_nxt;
                out_raddr_1 <= in_rs1;
                out_raddr_2 <= in_rs2;
            end
            if (state == EX) begin
                out_wen   <= legal && rd_q != '0;
                out_waddr <= rd_q;
                out_wdata <= res;
                out_done  <= 1'b1;
                out_err   <= !legal;
            end
            if (state == WB && !out_err) out_retire_cnt <= out_retire_cnt + CNT_W'(1);
        end
    end
endmodule
